tcm_ram_dp: RTL and testbench

//  Parametrised dual-port tightly-coupled memory: byte-lane writable word array for the pipeline.

---
 rtl/tcm_ram_dp.sv | 156 +++++++++++++++
 tb/tb_tcm_ram_dp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tcm_ram_dp.sv
// tcm_ram_dp: dual-port tightly-coupled memory.
//  - Port I is an instruction-fetch read port. Port D is a data read/write port with byte enables.
//  - Both ports use a req/gnt/rvalid handshake. Read latency is 1 or 2 cycles (RD_LAT).
//  - After reset, a sweep zeroes the array one word per cycle, so the array has no reset of its own.
//  - Optional macro TCM_RD_ALIGN_EN: read data is shifted right by the byte offset of the address.
module tcm_ram_dp #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              init_done,
    input  logic              i_req,
    output logic              i_gnt,
    input  logic [31:0]       i_addr,
    output logic              i_rvalid,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    output logic              d_gnt,
    input  logic              d_we,
    input  logic [DWIDTH/8-1:0] d_be,
    input  logic [31:0]       d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata
);
    localparam int NB    = DWIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic              init_done_q;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] i_raw_q, d_raw_q;
    logic              i_v1_q, d_v1_q, d_rd1_q;
    logic [DWIDTH-1:0] i_s1, d_s1;

    logic [AWIDTH-1:0] i_idx, d_idx;
    logic              d_wr, d_rd;

    // Upper address bits wrap the array; the low bits only carry a byte offset.
    logic unused_addr;
    assign unused_addr = ^{i_addr, d_addr};

    assign i_idx     = i_addr[AWIDTH+OFF-1:OFF];
    assign d_idx     = d_addr[AWIDTH+OFF-1:OFF];
    assign init_done = init_done_q;
    assign i_gnt     = i_req & init_done_q;
    assign d_gnt     = d_req & init_done_q;
    assign d_wr      = d_gnt & d_we;
    assign d_rd      = d_gnt & ~d_we;

    // Init sweep FSM: walks cnt_q over every word, then parks in READY.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
            end
        end
    end

    // Array write (sweep or port D byte lanes) and read-first reads for both ports.
    // NOTE: the array is deliberately left out of the async reset; the init sweep clears it, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (!init_done_q) begin
            mem[cnt_q] <= '0;
        end else if (d_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
        i_raw_q <= mem[i_idx];
        d_raw_q <= mem[d_idx];
    end

    // First response stage: valid flags that qualify the raw array reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_v1_q  <= 1'b0;
            d_v1_q  <= 1'b0;
            d_rd1_q <= 1'b0;
        end else begin
            i_v1_q  <= i_gnt;
            d_v1_q  <= d_gnt;
            d_rd1_q <= d_rd;
        end
    end

`ifdef TCM_RD_ALIGN_EN
    localparam int OFFW = (OFF > 0) ? OFF : 1;

    logic [OFFW-1:0] i_off, d_off, i_off1_q, d_off1_q;

    assign i_off = (OFF > 0) ? i_addr[OFFW-1:0] : '0;
    assign d_off = (OFF > 0) ? d_addr[OFFW-1:0] : '0;

    // Byte offset travels with the read so the shift lines up with the data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_off1_q <= '0;
            d_off1_q <= '0;
        end else begin
            i_off1_q <= i_off;
            d_off1_q <= d_off;
        end
    end

    assign i_s1 = i_v1_q  ? (i_raw_q >> {i_off1_q, 3'b000}) : '0;
    assign d_s1 = d_rd1_q ? (d_raw_q >> {d_off1_q, 3'b000}) : '0;
`else
    assign i_s1 = i_v1_q  ? i_raw_q : '0;
    assign d_s1 = d_rd1_q ? d_raw_q : '0;
`endif

    if (RD_LAT == 2) begin : g_lat2
        logic              i_v2_q, d_v2_q;
        logic [DWIDTH-1:0] i_d2_q, d_d2_q;

        // Extra output register stage for the two-cycle read latency.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                i_v2_q <= 1'b0;
                d_v2_q <= 1'b0;
                i_d2_q <= '0;
                d_d2_q <= '0;
            end else begin
                i_v2_q <= i_v1_q;
                d_v2_q <= d_v1_q;
                i_d2_q <= i_s1;
                d_d2_q <= d_s1;
            end
        end

        assign i_rvalid = i_v2_q;
        assign i_rdata  = i_d2_q;
        assign d_rvalid = d_v2_q;
        assign d_rdata  = d_d2_q;
    end else begin : g_lat1
        assign i_rvalid = i_v1_q;
        assign i_rdata  = i_s1;
        assign d_rvalid = d_v1_q;
        assign d_rdata  = d_s1;
    end

endmodule

// File: tb/tb_tcm_ram_dp.sv
// Testbench for tcm_ram_dp: two instances (RD_LAT=1 and RD_LAT=2) driven by identical stimulus,
// checked every cycle against a word-array reference model.
module tb_tcm_ram_dp;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req, d_req, d_we;
    logic [31:0]   i_addr, d_addr;
    logic [NB-1:0] d_be;
    logic [DW-1:0] d_wdata;

    logic          init_done1, i_gnt1, i_rvalid1, d_gnt1, d_rvalid1;
    logic [DW-1:0] i_rdata1, d_rdata1;
    logic          init_done2, i_gnt2, i_rvalid2, d_gnt2, d_rvalid2;
    logic [DW-1:0] i_rdata2, d_rdata2;

    always #5 clk = ~clk;

    tcm_ram_dp #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .init_done(init_done1),
        .i_req(i_req), .i_gnt(i_gnt1), .i_addr(i_addr), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_gnt(d_gnt1), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1)
    );

    tcm_ram_dp #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .init_done(init_done2),
        .i_req(i_req), .i_gnt(i_gnt2), .i_addr(i_addr), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
        .d_req(d_req), .d_gnt(d_gnt2), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain word array, count of edges since reset release,
    // and expected responses per latency.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } resp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    int            edges;
    resp_t         ei1, ed1, ei2, ed2, pi2, pd2;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / NB) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rd_view(input logic [31:0] addr);
        logic [DW-1:0] w;
        w = ref_mem[word_of(addr)];
`ifdef TCM_RD_ALIGN_EN
        w = w >> (8 * (addr % NB));
`endif
        return w;
    endfunction

    task automatic set_idle();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        edges = 0;
        ei1 = '0; ed1 = '0; ei2 = '0; ed2 = '0; pi2 = '0; pd2 = '0;
    endtask

    // Called at a negedge with inputs set: checks grants, steps the model at the
    // rising edge, then checks responses at the next negedge.
    task automatic cycle();
        logic  rdy;
        resp_t ni, nd;
        int    w;
        #1;
        rdy = (edges >= DEPTH);
        check("i_gnt1", 32'(i_gnt1), 32'(i_req & rdy));
        check("d_gnt1", 32'(d_gnt1), 32'(d_req & rdy));
        check("i_gnt2", 32'(i_gnt2), 32'(i_req & rdy));
        check("d_gnt2", 32'(d_gnt2), 32'(d_req & rdy));
        @(posedge clk);
        ni = '0;
        nd = '0;
        if (rdy && i_req) begin
            ni.v = 1'b1;
            ni.d = rd_view(i_addr);
        end
        if (rdy && d_req) begin
            nd.v = 1'b1;
            nd.d = d_we ? '0 : rd_view(d_addr);
        end
        if (rdy && d_req && d_we) begin
            w = word_of(d_addr);
            for (int b = 0; b < NB; b++)
                if (d_be[b]) ref_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
        end
        edges++;
        ei1 = ni;  ed1 = nd;
        ei2 = pi2; ed2 = pd2;
        pi2 = ni;  pd2 = nd;
        @(negedge clk);
        check("init_done1", 32'(init_done1), 32'(edges >= DEPTH));
        check("init_done2", 32'(init_done2), 32'(edges >= DEPTH));
        check("i_rvalid1", 32'(i_rvalid1), 32'(ei1.v));
        check("i_rdata1",  i_rdata1,       ei1.d);
        check("d_rvalid1", 32'(d_rvalid1), 32'(ed1.v));
        check("d_rdata1",  d_rdata1,       ed1.d);
        check("i_rvalid2", 32'(i_rvalid2), 32'(ei2.v));
        check("i_rdata2",  i_rdata2,       ei2.d);
        check("d_rvalid2", 32'(d_rvalid2), 32'(ed2.v));
        check("d_rdata2",  d_rdata2,       ed2.d);
    endtask

    // Asynchronous reset: outputs must drop at once, before any clock edge.
    task automatic do_reset();
        rstn = 1'b1;
        #1;
        rstn = 1'b0;
        set_idle();
        #1;
        check("rst_i_rvalid1", 32'(i_rvalid1), 32'd0);
        check("rst_d_rvalid1", 32'(d_rvalid1), 32'd0);
        check("rst_i_rvalid2", 32'(i_rvalid2), 32'd0);
        check("rst_d_rvalid2", 32'(d_rvalid2), 32'd0);
        check("rst_i_rdata1",  i_rdata1, 32'd0);
        check("rst_d_rdata2",  d_rdata2, 32'd0);
        check("rst_init_done", 32'(init_done1 | init_done2), 32'd0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic d_wr(input logic [31:0] a, input logic [DW-1:0] data, input logic [NB-1:0] be);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = data; d_be = be;
    endtask

    task automatic d_rd(input logic [31:0] a);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = '0; d_wdata = '0;
    endtask

    task automatic i_rd(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    initial begin
        set_idle();
        do_reset();

        // Requests held across the sweep: no grant until the sweep finishes.
        i_rd(32'h08); d_rd(32'h0C);
        for (int k = 0; k < DEPTH + 2; k++) cycle();

        // Full write then fetch of the same word.
        set_idle(); d_wr(32'h08, 32'hDEADBEEF, 4'hF); cycle();
        set_idle(); i_rd(32'h08); cycle();
        set_idle(); cycle(); cycle();

        // Partial-lane write, read back, and aliased read.
        d_wr(32'h08, 32'h11223344, 4'b0101); cycle();
        set_idle(); d_rd(32'h08); cycle();
        d_rd(32'h48); cycle();
        set_idle(); cycle(); cycle();

        // Same-cycle fetch and write to one word: fetch sees the old value.
        i_rd(32'h08); d_wr(32'h08, 32'hCAFEF00D, 4'hF); cycle();
        set_idle(); i_rd(32'h08); cycle();
        set_idle(); cycle(); cycle();

        // Unaligned read, zero-lane write, back-to-back reads.
        d_wr(32'h08, 32'hDEADBEEF, 4'hF); cycle();
        set_idle(); i_rd(32'h09); d_rd(32'h0B); cycle();
        set_idle(); d_wr(32'h08, 32'h55555555, 4'h0); cycle();
        for (int k = 0; k < 4; k++) begin
            i_rd(32'(k * 4)); d_rd(32'h0A); cycle();
        end
        set_idle(); cycle(); cycle();

        // Reset while a read response is in flight, then re-init.
        i_rd(32'h08); d_rd(32'h08); cycle();
        do_reset();
        i_rd(32'h08); d_rd(32'h08);
        for (int k = 0; k < DEPTH + 3; k++) cycle();
        set_idle(); cycle(); cycle();

        // Randomized traffic; one reset in the middle.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            i_req   = ($urandom_range(0, 3) != 0);
            i_addr  = $urandom;
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_be    = NB'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
            cycle();
        end
        set_idle(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
